// File: rtl/nn_pkg.sv
// Shared definitions for the classifier output stage.
package nn_pkg;

   localparam int DEFAULT_NUM_CLASSES = 10;
   localparam int DEFAULT_SCORE_WIDTH = 48;

   typedef enum logic [1:0] {
      IDLE,
      STREAM,
      FINISH
   } state_t;

   typedef logic signed [DEFAULT_SCORE_WIDTH-1:0] score_t;

endpackage

// File: rtl/nn_score_reader_argmax_step.sv
// One argmax update: take the candidate on the first beat or when strictly
// greater, so equal scores keep the lower index.
module nn_argmax_step #(
   parameter int DATA_WIDTH = 48,
   parameter int IDX_WIDTH  = 4
)(
   input  logic signed [DATA_WIDTH-1:0] best,
   input  logic        [IDX_WIDTH-1:0]  best_idx,
   input  logic signed [DATA_WIDTH-1:0] cand,
   input  logic        [IDX_WIDTH-1:0]  cand_idx,
   input  logic                         first,
   output logic signed [DATA_WIDTH-1:0] new_best,
   output logic        [IDX_WIDTH-1:0]  new_idx
);

   // select the running maximum (signed compare over the full width)
   always_comb begin
      new_best = best;
      new_idx  = best_idx;
      if (first || (cand > best)) begin
         new_best = cand;
         new_idx  = cand_idx;
      end
   end

endmodule

// File: rtl/nn_score_reader.sv
// Snapshots the final-layer scores on start, streams them one per beat over
// valid/ready, and reports the argmax with a one-cycle done pulse.
module nn_score_reader
   import nn_pkg::*;
#(
   parameter int DATA_WIDTH  = DEFAULT_SCORE_WIDTH,
   parameter int NUM_CLASSES = DEFAULT_NUM_CLASSES,
   parameter int IDX_WIDTH   = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1
)(
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         start,
   input  logic signed [DATA_WIDTH-1:0] scores [0:NUM_CLASSES-1],
   output logic                         busy,
   output logic                         m_valid,
   input  logic                         m_ready,
   output logic signed [DATA_WIDTH-1:0] m_score,
   output logic        [IDX_WIDTH-1:0]  m_index,
   output logic                         m_last,
   output logic                         done,
   output logic        [IDX_WIDTH-1:0]  class_idx,
   output logic signed [DATA_WIDTH-1:0] class_score
);

   localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_CLASSES - 1);

   state_t                       state;
   state_t                       state_nxt;
   logic        [IDX_WIDTH-1:0]  ptr;
   logic signed [DATA_WIDTH-1:0] snap [0:NUM_CLASSES-1];
   logic signed [DATA_WIDTH-1:0] best;
   logic signed [DATA_WIDTH-1:0] best_nxt;
   logic        [IDX_WIDTH-1:0]  best_idx;
   logic        [IDX_WIDTH-1:0]  best_idx_nxt;
   logic                         at_last;
   logic                         xfer;

   assign at_last = (ptr == LAST_IDX);
   assign xfer    = m_valid && m_ready;

   nn_argmax_step #(
      .DATA_WIDTH (DATA_WIDTH),
      .IDX_WIDTH  (IDX_WIDTH)
   ) u_step (
      .best     (best),
      .best_idx (best_idx),
      .cand     (snap[ptr]),
      .cand_idx (ptr),
      .first    (ptr == '0),
      .new_best (best_nxt),
      .new_idx  (best_idx_nxt)
   );

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // next-state: start accepted only when idle, FINISH lasts one cycle
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = STREAM;
         STREAM:  if (xfer && at_last) state_nxt = FINISH;
         FINISH:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // stream and status outputs decoded from state; held stable while stalled
   always_comb begin
      m_valid = (state == STREAM);
      busy    = (state == STREAM);
      done    = (state == FINISH);
      m_last  = 1'b0;
      m_index = '0;
      m_score = '0;
      if (state == STREAM) begin
         m_last  = at_last;
         m_index = ptr;
         m_score = snap[ptr];
      end
   end

   // snapshot capture, beat pointer, running argmax and held result
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr         <= '0;
         best        <= '0;
         best_idx    <= '0;
         class_idx   <= '0;
         class_score <= '0;
         for (int unsigned i = 0; i < NUM_CLASSES; i++) begin
            snap[i] <= '0;
         end
      end else begin
         if (state == IDLE && start) begin
            ptr <= '0;
            for (int unsigned i = 0; i < NUM_CLASSES; i++) begin
               snap[i] <= scores[i];
            end
         end
         if (xfer) begin
            best     <= best_nxt;
            best_idx <= best_idx_nxt;
            // the result registers take the final compare directly so they
            // are already valid in the done cycle
            if (at_last) begin
               class_idx   <= best_idx_nxt;
               class_score <= best_nxt;
            end else begin
               ptr <= ptr + 1'b1;
            end
         end
      end
   end

endmodule

// File: doc/nn_score_reader.md
Name: nn_score_reader

Overview:
- Consumer at the output end of the two-layer classifier.
- On a start pulse, snapshots the 10 signed class scores from the final layer.
- Streams the scores one per beat over a valid/ready interface, tagged with index and last.
- While streaming, computes the argmax and presents the predicted class with a one-cycle done pulse.

Parameters:
- DATA_WIDTH, 48, signed score width (final-layer data width 40 + 8 growth bits).
- NUM_CLASSES, 10, number of scores / output neurons.
- IDX_WIDTH, 4, index width; equals $clog2(NUM_CLASSES), minimum 1.

Ports:
- clk  input  1  clock, all logic rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle request: capture scores this cycle.
- scores  input  signed [DATA_WIDTH-1:0] x [0:NUM_CLASSES-1]  final-layer outputs; sampled only on accepted start.
- busy  output  1  high from the cycle after accepted start until done.
- m_valid  output  1  stream beat valid.
- m_ready  input  1  downstream ready.
- m_score  output  signed DATA_WIDTH  current score.
- m_index  output  IDX_WIDTH  index of current score.
- m_last  output  1  high on beat NUM_CLASSES-1.
- done  output  1  one-cycle pulse: result valid.
- class_idx  output  IDX_WIDTH  argmax index, held until next done.
- class_score  output  signed DATA_WIDTH  max score, held until next done.

Behaviour:
- Reset (async assert, sync release): state=IDLE, busy=0, m_valid=0, m_last=0, done=0, m_index=0, m_score=0, class_idx=0, class_score=0, snapshot buffer cleared.
- FSM states: IDLE, STREAM, FINISH.
- IDLE: start=1 -> copy scores into snapshot buffer, ptr=0, go STREAM. start=0 -> stay.
- STREAM:
  - m_valid=1; m_score=buf[ptr]; m_index=ptr; m_last=(ptr==NUM_CLASSES-1).
  - Beat transfers when m_valid&&m_ready.
  - On transfer: if ptr==0 or buf[ptr] > best (signed compare), best<=buf[ptr] and best_idx<=ptr. Strictly greater only, so ties resolve to lowest index.
  - On transfer with m_last: go FINISH. Otherwise ptr++.
  - With m_ready=0, m_valid/m_score/m_index/m_last hold stable; no compare occurs.
- FINISH: one cycle. done=1; class_idx<=best_idx and class_score<=best, both visible in that same cycle. m_valid=0, busy=0. Next state IDLE.
  - Since FINISH lasts one cycle, a start there is ignored; it is accepted only in IDLE.
- start while busy (STREAM or FINISH) is ignored; the snapshot is not altered. The live scores input may change freely after capture.
- Latency: start accepted at cycle t -> first beat valid at t+1. With m_ready held high, beats occupy t+1..t+NUM_CLASSES and done pulses at t+NUM_CLASSES+1.
- Arithmetic: comparisons are two's-complement over the full DATA_WIDTH. No truncation or saturation; the most negative value is legal.
- rst_n asserted mid-stream aborts immediately to reset values. No done is produced; the stream is truncated with no m_last.
- NUM_CLASSES=1: single beat with m_last=1; class_idx=0.

Decomposition:
- Shared package nn_pkg:
  - state enum (IDLE, STREAM, FINISH).
  - score typedef: signed logic [DATA_WIDTH-1:0].
  - DEFAULT_NUM_CLASSES=10 and DEFAULT_SCORE_WIDTH=48, shared with the network top.
- Sub-module: none required. The compare/update step may optionally be factored as nn_argmax_step (combinational: best, best_idx, cand, cand_idx, first -> new best, new idx).
- Expected size ~150-200 lines of RTL.

Test Plan:
- Scores {5,-3,17,2,0,9,17,-100,4,1}, m_ready=1, start at cycle 10 -> beats at 11..20 with indices 0..9, m_last only on cycle 20; done at cycle 21 with class_idx=2, class_score=17 (tie resolved to lower index).
- All scores -1 except score[9]=-(2^47) -> class_idx=0, class_score=-1; the stream carries 0x800000000000 unchanged on index 9.
- Backpressure: m_ready toggles 1,0,0,1,... -> m_score/m_index stable while stalled; exactly 10 transfers; argmax correct; done one cycle after the 10th transfer.
- start pulsed again at beat 4 with all-zero scores -> ignored; the stream still shows the original values and busy stays high until done.
- rst_n low during beat 6 -> all outputs 0 asynchronously, no done. After release, a new start streams freshly captured scores from index 0.
- Back-to-back runs: start asserted in the cycle after done -> accepted, first beat one cycle later; class_idx from the previous run is held until the new done.
